// File: rtl/tam_toplayici.sv
// rtl/tam_toplayici.sv - full adder with a bit-serial LSB-first adder engine
// Optional carry statistics counter: define TAM_TOPLAYICI_CARRY_STATS_EN.
module tam_toplayici #(
    parameter int SER_LEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               A,
    input  logic               B,
    input  logic               Cin,
    output logic               S,
    output logic               Cout,
    input  logic               ser_en,
    input  logic               ser_start,
    output logic [SER_LEN-1:0] ser_word,
    output logic               ser_cout,
    output logic               ser_done,
    output logic               ser_busy,
    output logic [7:0]         carry_cnt
);

    localparam int CW = $clog2(SER_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SER_LEN - 1);

    if (SER_LEN < 2 || SER_LEN > 32) begin : g_bad_len
        $error("tam_toplayici: SER_LEN must be in 2..32");
    end

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

    logic [SER_LEN-1:0] word_q, word_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic carry_in;
    logic sum_bit;
    logic carry_out;
    logic consume;

    always_comb begin
        carry_in  = ser_start ? Cin : carry_q;
        sum_bit   = A ^ B ^ carry_in;
        carry_out = (A & B) | (A & carry_in) | (B & carry_in);
        // A non-start bit outside a word is dropped entirely.
        consume   = ser_en && (ser_start || busy_q);

        word_d  = word_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;

        if (consume) begin
            word_d  = {sum_bit, word_q[SER_LEN-1:1]};
            carry_d = carry_out;
            if (ser_start) begin
                cnt_d  = CW'(1);
                busy_d = 1'b1;
            end else if (cnt_q == LAST_CNT) begin
                cnt_d  = '0;
                busy_d = 1'b0;
                done_d = 1'b1;
                cout_d = carry_out;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q  <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            word_q  <= word_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_word = word_q;
    assign ser_cout = cout_q;
    assign ser_done = done_q;
    assign ser_busy = busy_q;

`ifdef TAM_TOPLAYICI_CARRY_STATS_EN
    logic [7:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (Cout && stat_q != 8'hFF) begin
            stat_d = stat_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign carry_cnt = stat_q;
`else
    assign carry_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_tam_toplayici.sv
// tb/tb_tam_toplayici.sv - randomized and directed bench for tam_toplayici
module tb_tam_toplayici;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_in, b_in, cin_in;
    logic         s_out, cout_out;
    logic         ser_en, ser_start;
    logic [N-1:0] ser_word;
    logic         ser_cout, ser_done, ser_busy;
    logic [7:0]   carry_cnt;

    int total = 0;
    int bad   = 0;

    // reference model: operands accumulated per word, summed arithmetically
    int          m_busy, m_idx, m_cin, m_cnt, m_done_seen;
    logic [63:0] m_opa, m_opb, m_sum;
    logic [N-1:0] m_word;
    logic        m_cout, m_done;

    tam_toplayici #(.SER_LEN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a_in),
        .B         (b_in),
        .Cin       (cin_in),
        .S         (s_out),
        .Cout      (cout_out),
        .ser_en    (ser_en),
        .ser_start (ser_start),
        .ser_word  (ser_word),
        .ser_cout  (ser_cout),
        .ser_done  (ser_done),
        .ser_busy  (ser_busy),
        .carry_cnt (carry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clock(input logic en, input logic st, input logic a,
                               input logic b, input logic c, input logic rn);
        int ones;
        ones = int'(a) + int'(b) + int'(c);
        if (!rn) begin
            m_busy = 0; m_idx = 0; m_word = '0; m_cout = 1'b0;
            m_done = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
`ifdef TAM_TOPLAYICI_CARRY_STATS_EN
            if (ones >= 2 && m_cnt < 255) m_cnt++;
`endif
            if (en && (st || m_busy != 0)) begin
                if (st) begin
                    m_idx = 0; m_opa = '0; m_opb = '0; m_cin = int'(c);
                end
                m_opa = m_opa | (64'(a) << m_idx);
                m_opb = m_opb | (64'(b) << m_idx);
                m_idx++;
                if (m_idx == N) begin
                    m_sum  = m_opa + m_opb + 64'(m_cin);
                    m_word = m_sum[N-1:0];
                    m_cout = m_sum[N];
                    m_done = 1'b1;
                    m_busy = 0;
                end else begin
                    m_busy = 1;
                end
            end
        end
    endtask

    task automatic step(input logic en, input logic st, input logic a,
                        input logic b, input logic c, input logic rn);
        int exp_sum;
        ser_en = en; ser_start = st; a_in = a; b_in = b; cin_in = c; rst_n = rn;
        #1;
        exp_sum = int'(a) + int'(b) + int'(c);
        check("comb_s", 32'(s_out), 32'(exp_sum % 2));
        check("comb_cout", 32'(cout_out), 32'(exp_sum / 2));
        @(posedge clk);
        model_clock(en, st, a, b, c, rn);
        #1;
        if (ser_done) m_done_seen++;
        check("ser_done", 32'(ser_done), 32'(m_done));
        check("ser_busy", 32'(ser_busy), 32'(m_busy != 0));
        check("ser_cout", 32'(ser_cout), 32'(m_cout));
        check("carry_cnt", 32'(carry_cnt), 32'(m_cnt));
        if (m_busy == 0) check("ser_word", 32'(ser_word), 32'(m_word));
    endtask

    task automatic send(input logic [N-1:0] wa, input logic [N-1:0] wb,
                        input logic c, input int stall_after);
        for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, wa[i], wb[i], c, 1'b1);
            if (i == stall_after) begin
                step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
                step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            end
        end
    endtask

    initial begin
        logic [7:0] exp_tab;
        logic [7:0] exp_cy;
        int done_before;
        m_done_seen = 0; m_opa = '0; m_opb = '0; m_cin = 0;

        // combinational truth table before any clock or reset
        exp_tab = 8'b1001_0110;
        exp_cy  = 8'b1110_1000;
        rst_n = 1'b0; ser_en = 1'b0; ser_start = 1'b0;
        for (int v = 0; v < 8; v++) begin
            {a_in, b_in, cin_in} = 3'(v);
            #1;
            check("tt_s", 32'(s_out), 32'(exp_tab[v]));
            check("tt_cout", 32'(cout_out), 32'(exp_cy[v]));
        end

        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_word", 32'(ser_word), 32'h0);
        check("rst_busy", 32'(ser_busy), 32'h0);
        check("rst_done", 32'(ser_done), 32'h0);
        check("rst_cnt", 32'(carry_cnt), 32'h0);

        done_before = m_done_seen;
        send(8'h5A, 8'h3C, 1'b0, -1);
        check("w5a3c_word", 32'(ser_word), 32'h96);
        check("w5a3c_cout", 32'(ser_cout), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("w5a3c_pulses", 32'(m_done_seen - done_before), 32'd1);

        send(8'hFF, 8'h01, 1'b0, 3);
        check("wff01_word", 32'(ser_word), 32'h00);
        check("wff01_cout", 32'(ser_cout), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("wff01_busy", 32'(ser_busy), 32'h0);

        // reset abandons a word after four bits
        done_before = m_done_seen;
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("midrst_word", 32'(ser_word), 32'h0);
        check("midrst_cout", 32'(ser_cout), 32'h0);
        check("midrst_busy", 32'(ser_busy), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("midrst_nodone", 32'(m_done_seen - done_before), 32'd0);
        send(8'h01, 8'h01, 1'b1, -1);
        check("w0101_word", 32'(ser_word), 32'h03);

        // stray non-start bits while idle must be ignored
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("idle_ignore", 32'(ser_word), 32'h03);

        // restart mid-word discards the partial word
        for (int i = 0; i < 3; i++) step(1'b1, i == 0, 1'b1, 1'b1, 1'b0, 1'b1);
        send(8'h10, 8'h22, 1'b0, 5);
        check("restart_word", 32'(ser_word), 32'h32);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef TAM_TOPLAYICI_CARRY_STATS_EN
        check("sat_cnt", 32'(carry_cnt), 32'd255);
`else
        check("sat_cnt", 32'(carry_cnt), 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 99) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
